// File: rtl/cv32e40p_pkg.sv
// cv32e40p_pkg
//   Shared types and constants for the write-back arbiter slice.
//   arb_mode_e : ARB_RR (rotating priority) or ARB_FIXED (lowest index wins)
//   CONT_CNT_W : width of the saturating contention counter
package cv32e40p_pkg;

    typedef enum logic {
        ARB_RR    = 1'b0,
        ARB_FIXED = 1'b1
    } arb_mode_e;

    localparam int CONT_CNT_W = 16;

endpackage

// File: rtl/cv32e40p_wb_fifo.sv
// cv32e40p_wb_fifo
//   Per-channel result buffer. DEPTH must be a power of two so the pointers
//   wrap naturally.
//   Ports:
//     clk, rst      clock, async active-high reset
//     push, wdata   enqueue (ignored when full or flushing)
//     pop           dequeue head (ignored when empty or flushing)
//     flush         drop all contents, including a same-cycle push
//     full, empty   occupancy status
//     head          oldest entry (valid when !empty)
module cv32e40p_wb_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 38
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic             push_ok, pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cv32e40p_wb_arbiter.sv
// cv32e40p_wb_arbiter
//   Collects results from NUM_CH producers into per-channel FIFOs and
//   serialises them onto one register-file write port, one write per cycle.
//   Ports:
//     clk, rst                     clock, async active-high reset
//     ch_valid_i/waddr_i/wdata_i   per-channel result offer
//     ch_ready_o                   per-channel FIFO not full
//     wb_ready_i                   write port available (stalls grants only)
//     flush_i                      discard everything pending
//     cnt_clr_i                    clear contention counter
//     wb_we_o/waddr_o/wdata_o      registered write to register file
//     contention_o                 grant last cycle had a losing competitor
//     contention_cnt_o             saturating count of contention pulses
//     busy_o                       anything pending or being written
module cv32e40p_wb_arbiter
    import cv32e40p_pkg::*;
#(
    parameter int        NUM_CH   = 4,
    parameter int        DATA_W   = 32,
    parameter int        ADDR_W   = 6,
    parameter int        DEPTH    = 2,
    parameter arb_mode_e ARB_MODE = ARB_RR
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_CH-1:0]                 ch_valid_i,
    input  logic [NUM_CH-1:0][ADDR_W-1:0]     ch_waddr_i,
    input  logic [NUM_CH-1:0][DATA_W-1:0]     ch_wdata_i,
    output logic [NUM_CH-1:0]                 ch_ready_o,
    input  logic                              wb_ready_i,
    input  logic                              flush_i,
    input  logic                              cnt_clr_i,
    output logic                              wb_we_o,
    output logic [ADDR_W-1:0]                 wb_waddr_o,
    output logic [DATA_W-1:0]                 wb_wdata_o,
    output logic                              contention_o,
    output logic [CONT_CNT_W-1:0]             contention_cnt_o,
    output logic                              busy_o
);

    localparam int ENT_W = ADDR_W + DATA_W;
    localparam int CH_W  = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            full, empty, pending, push, gnt_oh;
    logic [NUM_CH-1:0][ENT_W-1:0] head;
    logic [CH_W-1:0]              rr_ptr, gnt_idx;
    logic                         gnt_en, found, others;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign push[g] = ch_valid_i[g] & ~full[g];

            cv32e40p_wb_fifo #(
                .DEPTH (DEPTH),
                .WIDTH (ENT_W)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (push[g]),
                .pop   (gnt_oh[g]),
                .flush (flush_i),
                .wdata ({ch_waddr_i[g], ch_wdata_i[g]}),
                .full  (full[g]),
                .empty (empty[g]),
                .head  (head[g])
            );
        end
    endgenerate

    // Ready comes from "full" alone, so a full FIFO refuses even while popping.
    assign ch_ready_o = ~full;
    assign pending    = ~empty;
    assign gnt_en     = wb_ready_i & ~flush_i & (|pending);

    always_comb begin
        gnt_idx = '0;
        found   = 1'b0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!found && pending[i]) begin
                    found   = 1'b1;
                    gnt_idx = CH_W'(i);
                end
            end
        end else begin
            // Scan starting at rr_ptr, wrapping around the channel count.
            for (int k = 0; k < NUM_CH; k++) begin
                if (!found && pending[(int'(rr_ptr) + k) % NUM_CH]) begin
                    found   = 1'b1;
                    gnt_idx = CH_W'((int'(rr_ptr) + k) % NUM_CH);
                end
            end
        end
    end

    assign gnt_oh = gnt_en ? (NUM_CH'(1) << gnt_idx) : '0;
    assign others = |(pending & ~gnt_oh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr       <= '0;
            wb_we_o      <= 1'b0;
            wb_waddr_o   <= '0;
            wb_wdata_o   <= '0;
            contention_o <= 1'b0;
        end else begin
            wb_we_o      <= gnt_en;
            contention_o <= gnt_en & others;
            if (gnt_en) begin
                {wb_waddr_o, wb_wdata_o} <= head[gnt_idx];
                rr_ptr <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
            end
        end
    end

    // Counts contention_o pulses; clear has priority over a same-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contention_cnt_o <= '0;
        end else if (cnt_clr_i) begin
            contention_cnt_o <= '0;
        end else if (contention_o && (contention_cnt_o != '1)) begin
            contention_cnt_o <= contention_cnt_o + CONT_CNT_W'(1);
        end
    end

    assign busy_o = (|pending) | wb_we_o;

endmodule
